// File: rtl/serpent_xts_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serpent_xts_pkg                                                            |
// | Shared XTS constants and sequencer state encoding.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package serpent_xts_pkg;

  localparam int BLK_W = 128;
  localparam logic [BLK_W-1:0] XTS_POLY = 128'h87;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TWK_REQ = 3'd1,
    BLK_IN  = 3'd2,
    BLK_REQ = 3'd3,
    BLK_OUT = 3'd4
  } xts_state_e;

endpackage
`default_nettype wire

// File: rtl/xts_gf_dbl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xts_gf_dbl                                                                 |
// | Combinational multiply-by-alpha in GF(2^128), XTS little-endian layout.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xts_gf_dbl
  import serpent_xts_pkg::*;
(
  input  logic [BLK_W-1:0] i_t,
  output logic [BLK_W-1:0] o_t
);

  logic [BLK_W-1:0] w_shifted;
  logic [BLK_W-1:0] w_fold;

  assign w_shifted = {i_t[BLK_W-2:0], 1'b0};
  // The bit shifted out of the top reduces back in through the field polynomial.
  assign w_fold    = i_t[BLK_W-1] ? XTS_POLY : '0;
  assign o_t       = w_shifted ^ w_fold;

endmodule
`default_nettype wire

// File: rtl/serpent_xts_sector_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serpent_xts_sector_engine                                                  |
// | XTS sector sequencer: tweak generation, per-block whitening, core calls.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serpent_xts_sector_engine
  import serpent_xts_pkg::*;
#(
  parameter int BLKS_PER_SECTOR = 32,
  parameter int SECTOR_W        = 64,
  parameter int CNT_W           = $clog2(BLKS_PER_SECTOR + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sector_valid,
  output logic                o_sector_ready,
  input  logic [SECTOR_W-1:0] i_sector_num,
  input  logic                i_decrypt,
  input  logic                i_data_valid,
  output logic                o_data_ready,
  input  logic [BLK_W-1:0]    i_data,
  output logic                o_data_valid,
  input  logic                i_out_ready,
  output logic [BLK_W-1:0]    o_data,
  output logic                o_last,
  output logic                o_sector_done,
  output logic                o_core_req,
  output logic                o_core_key_sel,
  output logic                o_core_decrypt,
  output logic [BLK_W-1:0]    o_core_data,
  input  logic                i_core_ack,
  input  logic [BLK_W-1:0]    i_core_data
);

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(BLKS_PER_SECTOR - 1);

  xts_state_e       r_state;
  logic [BLK_W-1:0] r_tweak;
  logic [BLK_W-1:0] r_core_data;
  logic [BLK_W-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_sector_ready;
  logic             r_data_ready;
  logic             r_data_valid;
  logic             r_last;
  logic             r_done;
  logic             r_core_req;
  logic             r_key_sel;
  logic             r_core_dec;
  logic [BLK_W-1:0] w_tweak_dbl;

  xts_gf_dbl u_dbl (
    .i_t (r_tweak),
    .o_t (w_tweak_dbl)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_tweak        <= '0;
      r_core_data    <= '0;
      r_data         <= '0;
      r_cnt          <= '0;
      r_mode         <= 1'b0;
      r_sector_ready <= 1'b1;
      r_data_ready   <= 1'b0;
      r_data_valid   <= 1'b0;
      r_last         <= 1'b0;
      r_done         <= 1'b0;
      r_core_req     <= 1'b0;
      r_key_sel      <= 1'b0;
      r_core_dec     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_sector_valid) begin
            r_mode         <= i_decrypt;
            r_core_data    <= BLK_W'(i_sector_num);
            r_key_sel      <= 1'b1;
            r_core_dec     <= 1'b0;
            r_cnt          <= '0;
            r_sector_ready <= 1'b0;
            r_core_req     <= 1'b1;
            r_state        <= TWK_REQ;
          end
        end
        TWK_REQ: begin
          if (i_core_ack) begin
            r_tweak      <= i_core_data;
            r_core_req   <= 1'b0;
            r_data_ready <= 1'b1;
            r_state      <= BLK_IN;
          end
        end
        BLK_IN: begin
          if (i_data_valid) begin
            r_core_data  <= i_data ^ r_tweak;
            r_key_sel    <= 1'b0;
            r_core_dec   <= r_mode;
            r_data_ready <= 1'b0;
            r_core_req   <= 1'b1;
            r_state      <= BLK_REQ;
          end
        end
        BLK_REQ: begin
          if (i_core_ack) begin
            r_data       <= i_core_data ^ r_tweak;
            r_core_req   <= 1'b0;
            r_data_valid <= 1'b1;
            r_last       <= (r_cnt == c_LAST_CNT);
            r_state      <= BLK_OUT;
          end
        end
        BLK_OUT: begin
          if (i_out_ready) begin
            // Tweak advances once per delivered block, identically for both directions.
            r_tweak      <= w_tweak_dbl;
            r_data_valid <= 1'b0;
            r_last       <= 1'b0;
            if (r_last) begin
              r_done         <= 1'b1;
              r_sector_ready <= 1'b1;
              r_state        <= IDLE;
            end else begin
              r_cnt        <= r_cnt + 1'b1;
              r_data_ready <= 1'b1;
              r_state      <= BLK_IN;
            end
          end
        end
        default: begin
          r_state        <= IDLE;
          r_sector_ready <= 1'b1;
          r_data_ready   <= 1'b0;
          r_data_valid   <= 1'b0;
          r_last         <= 1'b0;
          r_core_req     <= 1'b0;
        end
      endcase
    end
  end

  assign o_sector_ready = r_sector_ready;
  assign o_data_ready   = r_data_ready;
  assign o_data_valid   = r_data_valid;
  assign o_data         = r_data;
  assign o_last         = r_last;
  assign o_sector_done  = r_done;
  assign o_core_req     = r_core_req;
  assign o_core_key_sel = r_key_sel;
  assign o_core_decrypt = r_core_dec;
  assign o_core_data    = r_core_data;

endmodule
`default_nettype wire

// File: tb/tb_serpent_xts_sector_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serpent_xts_sector_engine                                               |
// | Directed bench with a stub core (K2 = identity, K1 = bitwise invert).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serpent_xts_sector_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sector_valid = 1'b0;
  logic         sector_ready;
  logic [63:0]  sector_num = '0;
  logic         decrypt = 1'b0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic [127:0] data_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic         sector_done;
  logic         core_req;
  logic         core_key_sel;
  logic         core_decrypt;
  logic [127:0] core_op;
  logic         stub_ack = 1'b0;
  logic         late_ack = 1'b0;
  logic         core_ack;
  logic [127:0] core_res = '0;
  logic         stub_hold = 1'b0;
  logic [127:0] gf_in = '0;
  logic [127:0] gf_out;

  int checks = 0;
  int failures = 0;
  int req_cycles = 0;

  typedef struct packed {
    logic         ks;
    logic         dec;
    logic [127:0] d;
  } op_t;
  op_t ops[$];

  localparam logic [127:0] D1  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] ND1 = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] D2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ND2 = 128'hffeeddccbbaa99887766554433221100;

  assign core_ack = stub_ack | late_ack;

  always #5 clk = ~clk;

  serpent_xts_sector_engine #(
    .BLKS_PER_SECTOR (4),
    .SECTOR_W        (64)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sector_valid (sector_valid),
    .o_sector_ready (sector_ready),
    .i_sector_num   (sector_num),
    .i_decrypt      (decrypt),
    .i_data_valid   (data_valid),
    .o_data_ready   (data_ready),
    .i_data         (data_in),
    .o_data_valid   (out_valid),
    .i_out_ready    (out_ready),
    .o_data         (out_data),
    .o_last         (out_last),
    .o_sector_done  (sector_done),
    .o_core_req     (core_req),
    .o_core_key_sel (core_key_sel),
    .o_core_decrypt (core_decrypt),
    .o_core_data    (core_op),
    .i_core_ack     (core_ack),
    .i_core_data    (core_res)
  );

  xts_gf_dbl u_gf (
    .i_t (gf_in),
    .o_t (gf_out)
  );

  // Stub core: random 0-5 cycle ack latency, ack driven for the upcoming edge.
  int  lat = 0;
  bit  armed = 1'b0;
  always @(negedge clk) begin
    stub_ack = 1'b0;
    if (rst || !core_req || stub_hold) begin
      armed = 1'b0;
    end else begin
      if (!armed) begin
        armed = 1'b1;
        lat = int'($urandom_range(0, 5));
      end
      if (lat == 0) begin
        stub_ack = 1'b1;
        core_res = core_key_sel ? core_op : ~core_op;
        armed    = 1'b0;
      end else begin
        lat = lat - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (core_req) req_cycles <= req_cycles + 1;
    if (!rst && core_req && core_ack) ops.push_back({core_key_sel, core_decrypt, core_op});
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_sector(input logic [63:0] num, input logic dec);
    sector_num   = num;
    decrypt      = dec;
    sector_valid = 1'b1;
    @(negedge clk);
    sector_valid = 1'b0;
    chk("sector_ready_busy", sector_ready, 1'b0);
  endtask

  task automatic do_block(input logic [127:0] d, input logic [127:0] exp_o,
                          input logic exp_last, input int hold);
    int n;
    int req0;
    n = 0;
    while (!data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("data_ready_wait", data_ready, 1'b1);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_wait", out_valid, 1'b1);
    chk("o_data", out_data, exp_o);
    chk("o_last", out_last, exp_last);
    req0 = req_cycles;
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("hold_o_data", out_data, exp_o);
      chk("hold_o_last", out_last, exp_last);
      chk("hold_data_ready", data_ready, 1'b0);
      chk("hold_core_req_cycles", 128'(req_cycles - req0), 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("sector_done", sector_done, exp_last);
    chk("out_valid_after", out_valid, 1'b0);
    if (exp_last) begin
      chk("sector_ready_done", sector_ready, 1'b1);
      @(negedge clk);
      chk("done_pulse_width", sector_done, 1'b0);
    end
  endtask

  task automatic check_ops(input logic [127:0] t0, input logic [127:0] t1,
                           input logic [127:0] t2, input logic [127:0] t3,
                           input logic [127:0] d, input logic dec);
    logic [127:0] tw [4];
    tw[0] = t0; tw[1] = t1; tw[2] = t2; tw[3] = t3;
    chk("core_call_count", 128'(ops.size()), 128'd5);
    if (ops.size() == 5) begin
      chk("twk_operand", ops[0].d, t0);
      chk("twk_key_sel", ops[0].ks, 1'b1);
      chk("twk_decrypt", ops[0].dec, 1'b0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("blk%0d_operand", i), ops[i+1].d, d ^ tw[i]);
        chk($sformatf("blk%0d_key_sel", i), ops[i+1].ks, 1'b0);
        chk($sformatf("blk%0d_decrypt", i), ops[i+1].dec, dec);
      end
    end
    ops.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sector_ready", sector_ready, 1'b1);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_o_data", out_data, 128'd0);
    chk("rst_core_req", core_req, 1'b0);
    chk("rst_core_data", core_op, 128'd0);
    chk("rst_key_sel", core_key_sel, 1'b0);
    chk("rst_done", sector_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // GF doubling unit checks
    gf_in = 128'h80000000000000000000000000000001; #1;
    chk("gf_carry_fold", gf_out, 128'h85);
    gf_in = 128'h1; #1;
    chk("gf_shift", gf_out, 128'h2);
    gf_in = 128'hffffffffffffffffffffffffffffffff; #1;
    chk("gf_all_ones", gf_out, 128'hffffffffffffffffffffffffffffff79);

    // Encrypt sector 5
    ops.delete();
    send_sector(64'd5, 1'b0);
    do_block(D1, ND1, 1'b0, 0);
    do_block(D1, ND1, 1'b0, 0);
    do_block(D1, ND1, 1'b0, 0);
    do_block(D1, ND1, 1'b1, 0);
    check_ops(128'h5, 128'hA, 128'h14, 128'h28, D1, 1'b0);

    // Decrypt sector 5 with 10 cycles of output backpressure on block 1
    send_sector(64'd5, 1'b1);
    do_block(D2, ND2, 1'b0, 0);
    do_block(D2, ND2, 1'b0, 10);
    do_block(D2, ND2, 1'b0, 0);
    do_block(D2, ND2, 1'b1, 0);
    check_ops(128'h5, 128'hA, 128'h14, 128'h28, D2, 1'b1);

    // Reset with a data-phase core request outstanding
    send_sector(64'd9, 1'b0);
    for (int n = 0; n < 50 && !data_ready; n++) @(negedge clk);
    stub_hold  = 1'b1;
    data_in    = D1;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("pending_core_req", core_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_core_req", core_req, 1'b0);
    chk("midrst_sector_ready", sector_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_o_data", out_data, 128'd0);
    chk("midrst_core_data", core_op, 128'd0);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    chk("late_ack_sector_ready", sector_ready, 1'b1);
    chk("late_ack_core_req", core_req, 1'b0);
    chk("late_ack_data_ready", data_ready, 1'b0);
    stub_hold = 1'b0;
    ops.delete();

    // Sector 0 after reset: zero tweak, operands equal the data
    send_sector(64'd0, 1'b0);
    do_block(D1, ND1, 1'b0, 0);
    do_block(D2, ND2, 1'b0, 0);
    do_block(D1, ND1, 1'b0, 0);
    do_block(D1, ND1, 1'b1, 0);
    chk("s0_call_count", 128'(ops.size()), 128'd5);
    if (ops.size() == 5) begin
      chk("s0_twk_operand", ops[0].d, 128'd0);
      chk("s0_blk0_operand", ops[1].d, D1);
      chk("s0_blk1_operand", ops[2].d, D2);
      chk("s0_blk3_operand", ops[4].d, D1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
